// File: rtl/binarization_adaptive.sv
// binarization_adaptive: converts a DW-bit grey pixel stream into a 1-bit
// monochrome stream. Supports a fixed threshold, an automatic threshold taken
// from the previous frame's min/max midpoint, and an optional hysteresis band
// around either one. Output polarity can be inverted. The block also produces
// line-edge pulses and a white-pixel count for each frame.
//
// Ports:
//   clk, rst                  pixel clock, synchronous active-high reset
//   pre_frame_vsync/hsync/de  input sync and data enable
//   color                     input pixel (DW bits)
//   thresh_cfg, hyst_cfg      fixed threshold and hysteresis half-band
//   mode_cfg                  00 fixed, 01 auto, 10 fixed+hyst, 11 auto+hyst
//   invert_cfg                invert monoc polarity
//   post_frame_vsync/hsync/de sync inputs delayed by 2 cycles
//   monoc                     1 = white, 0 = black; forced to 0 outside de
//   monoc_rise/monoc_fall     monoc edge pulses inside an active line
//   auto_thresh               midpoint threshold from the last completed frame
//   white_cnt/white_cnt_valid white pixels of the last frame, plus update strobe
module binarization_adaptive #(
    parameter int unsigned DW          = 8,
    parameter int unsigned THRESH_INIT = 64,
    parameter int unsigned CNT_W       = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pre_frame_vsync,
    input  logic             pre_frame_hsync,
    input  logic             pre_frame_de,
    input  logic [DW-1:0]    color,
    input  logic [DW-1:0]    thresh_cfg,
    input  logic [DW-1:0]    hyst_cfg,
    input  logic [1:0]       mode_cfg,
    input  logic             invert_cfg,
    output logic             post_frame_vsync,
    output logic             post_frame_hsync,
    output logic             post_frame_de,
    output logic             monoc,
    output logic             monoc_rise,
    output logic             monoc_fall,
    output logic [DW-1:0]    auto_thresh,
    output logic [CNT_W-1:0] white_cnt,
    output logic             white_cnt_valid
);

    localparam int unsigned EW = DW + 1;
    localparam logic [DW-1:0]    PIX_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [DW-1:0]    THR_RST = DW'(THRESH_INIT);

    // stage 1
    logic [DW-1:0] color_s1_q, color_s1_d;
    logic          de_s1_q, de_s1_d;
    logic          hs_s1_q, hs_s1_d;
    logic          vs_s1_q, vs_s1_d;
    logic          vs_s1_dly_q, vs_s1_dly_d;

    // committed config and frame statistics
    logic [DW-1:0] act_thresh_q, act_thresh_d;
    logic [DW-1:0] act_hyst_q, act_hyst_d;
    logic [1:0]    act_mode_q, act_mode_d;
    logic          act_invert_q, act_invert_d;
    logic [DW-1:0] auto_thresh_q, auto_thresh_d;
    logic [DW-1:0] min_q, min_d;
    logic [DW-1:0] max_q, max_d;
    logic          seen_q, seen_d;

    // stage 2 and outputs
    logic          w_q, w_d;
    logic          monoc_q, monoc_d;
    logic          monoc_dly_q, monoc_dly_d;
    logic          post_vs_q, post_vs_d;
    logic          post_hs_q, post_hs_d;
    logic          post_de_q, post_de_d;
    logic          post_vs_dly_q, post_vs_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] white_cnt_q, white_cnt_d;
    logic          white_cnt_valid_q, white_cnt_valid_d;

    // combinational helpers
    logic          vs_rise;
    logic          line_start;
    logic          post_vs_rise;
    logic [EW-1:0] mm_sum;
    logic [DW-1:0] thr_eff;
    logic [EW-1:0] hi_sum;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          w_prev;
    logic          w_cur;
    logic [CNT_W-1:0] cnt_next;

    assign vs_rise      = vs_s1_q & ~vs_s1_dly_q;
    // post_de_q is de_s1 delayed by one cycle, so this marks the first pixel of a line
    assign line_start   = de_s1_q & ~post_de_q;
    assign post_vs_rise = post_vs_q & ~post_vs_dly_q;
    assign mm_sum       = EW'(min_q) + EW'(max_q);

    // next-state logic
    always_comb begin
        color_s1_d        = color;
        de_s1_d           = pre_frame_de;
        hs_s1_d           = pre_frame_hsync;
        vs_s1_d           = pre_frame_vsync;
        vs_s1_dly_d       = vs_s1_q;
        act_thresh_d      = act_thresh_q;
        act_hyst_d        = act_hyst_q;
        act_mode_d        = act_mode_q;
        act_invert_d      = act_invert_q;
        auto_thresh_d     = auto_thresh_q;
        min_d             = min_q;
        max_d             = max_q;
        seen_d            = seen_q;
        w_d               = w_q;
        monoc_d           = 1'b0;
        monoc_dly_d       = monoc_q;
        post_vs_d         = vs_s1_q;
        post_hs_d         = hs_s1_q;
        post_de_d         = de_s1_q;
        post_vs_dly_d     = post_vs_q;
        cnt_d             = cnt_q;
        white_cnt_d       = white_cnt_q;
        white_cnt_valid_d = 1'b0;
        thr_eff           = '0;
        hi_sum            = '0;
        hi                = '0;
        lo                = '0;
        w_prev            = 1'b0;
        w_cur             = 1'b0;
        cnt_next          = cnt_q;

        // frame boundary: commit config, publish the midpoint, restart statistics
        if (vs_rise) begin
            act_thresh_d = thresh_cfg;
            act_hyst_d   = hyst_cfg;
            act_mode_d   = mode_cfg;
            act_invert_d = invert_cfg;
            if (seen_q) begin
                auto_thresh_d = DW'(mm_sum >> 1);
            end
            min_d  = PIX_MAX;
            max_d  = '0;
            seen_d = 1'b0;
        end

        // a pixel coinciding with vs_rise starts the fresh statistics
        if (de_s1_q) begin
            if (vs_rise || (color_s1_q < min_q)) begin
                min_d = color_s1_q;
            end
            if (vs_rise || (color_s1_q > max_q)) begin
                max_d = color_s1_q;
            end
            seen_d = 1'b1;
        end

        // the _d values make a same-cycle commit take effect on this pixel
        thr_eff = act_mode_d[0] ? auto_thresh_d : act_thresh_d;
        hi_sum  = EW'(thr_eff) + EW'(act_hyst_d);
        hi      = (hi_sum > EW'(PIX_MAX)) ? PIX_MAX : hi_sum[DW-1:0];
        lo      = (thr_eff >= act_hyst_d) ? (thr_eff - act_hyst_d) : '0;
        w_prev  = line_start ? 1'b0 : w_q;

        if (act_mode_d[1]) begin
            if (color_s1_q > hi) begin
                w_cur = 1'b1;
            end else if (color_s1_q < lo) begin
                w_cur = 1'b0;
            end else begin
                w_cur = w_prev;
            end
        end else begin
            w_cur = (color_s1_q > thr_eff);
        end

        if (de_s1_q) begin
            w_d     = w_cur;
            monoc_d = w_cur ^ act_invert_d;
        end

        // saturating white counter, snapshotted on the delayed vsync edge
        if (monoc_q && (cnt_q != CNT_MAX)) begin
            cnt_next = cnt_q + CNT_W'(1);
        end
        if (post_vs_rise) begin
            white_cnt_d       = cnt_next;
            white_cnt_valid_d = 1'b1;
            cnt_d             = '0;
        end else begin
            cnt_d = cnt_next;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            color_s1_q        <= '0;
            de_s1_q           <= 1'b0;
            hs_s1_q           <= 1'b0;
            vs_s1_q           <= 1'b0;
            vs_s1_dly_q       <= 1'b0;
            act_thresh_q      <= THR_RST;
            act_hyst_q        <= '0;
            act_mode_q        <= 2'b00;
            act_invert_q      <= 1'b0;
            auto_thresh_q     <= THR_RST;
            min_q             <= PIX_MAX;
            max_q             <= '0;
            seen_q            <= 1'b0;
            w_q               <= 1'b0;
            monoc_q           <= 1'b0;
            monoc_dly_q       <= 1'b0;
            post_vs_q         <= 1'b0;
            post_hs_q         <= 1'b0;
            post_de_q         <= 1'b0;
            post_vs_dly_q     <= 1'b0;
            cnt_q             <= '0;
            white_cnt_q       <= '0;
            white_cnt_valid_q <= 1'b0;
        end else begin
            color_s1_q        <= color_s1_d;
            de_s1_q           <= de_s1_d;
            hs_s1_q           <= hs_s1_d;
            vs_s1_q           <= vs_s1_d;
            vs_s1_dly_q       <= vs_s1_dly_d;
            act_thresh_q      <= act_thresh_d;
            act_hyst_q        <= act_hyst_d;
            act_mode_q        <= act_mode_d;
            act_invert_q      <= act_invert_d;
            auto_thresh_q     <= auto_thresh_d;
            min_q             <= min_d;
            max_q             <= max_d;
            seen_q            <= seen_d;
            w_q               <= w_d;
            monoc_q           <= monoc_d;
            monoc_dly_q       <= monoc_dly_d;
            post_vs_q         <= post_vs_d;
            post_hs_q         <= post_hs_d;
            post_de_q         <= post_de_d;
            post_vs_dly_q     <= post_vs_dly_d;
            cnt_q             <= cnt_d;
            white_cnt_q       <= white_cnt_d;
            white_cnt_valid_q <= white_cnt_valid_d;
        end
    end

    assign post_frame_vsync = post_vs_q;
    assign post_frame_hsync = post_hs_q;
    assign post_frame_de    = post_de_q;
    assign monoc            = monoc_q;
    assign monoc_rise       = post_de_q & ~monoc_dly_q & monoc_q;
    assign monoc_fall       = post_de_q & monoc_dly_q & ~monoc_q;
    assign auto_thresh      = auto_thresh_q;
    assign white_cnt        = white_cnt_q;
    assign white_cnt_valid  = white_cnt_valid_q;

endmodule

// File: tb/tb_binarization_adaptive.sv
// Testbench for binarization_adaptive: randomized and directed frames checked
// cycle by cycle against a frame-level behavioural model.
module tb_binarization_adaptive;

    localparam int PMAX  = 255;
    localparam int CMAX  = (1 << 22) - 1;
    localparam int CMAX3 = 7;

    typedef struct {
        bit rst;
        bit vs;
        bit hs;
        bit de;
        int col;
        int thr;
        int hy;
        int md;
        bit inv;
    } smp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vs_in, hs_in, de_in, invert_cfg;
    logic [7:0] color, thresh_cfg, hyst_cfg;
    logic [1:0] mode_cfg;

    logic        post_frame_vsync, post_frame_hsync, post_frame_de;
    logic        monoc, monoc_rise, monoc_fall, white_cnt_valid;
    logic [7:0]  auto_thresh;
    logic [21:0] white_cnt;
    logic        pvs3, phs3, pde3, monoc3, rise3, fall3, wcv3;
    logic [7:0]  auto3;
    logic [2:0]  wc3;

    binarization_adaptive #(.DW(8), .THRESH_INIT(64), .CNT_W(22)) dut (
        .clk(clk), .rst(rst),
        .pre_frame_vsync(vs_in), .pre_frame_hsync(hs_in), .pre_frame_de(de_in),
        .color(color), .thresh_cfg(thresh_cfg), .hyst_cfg(hyst_cfg),
        .mode_cfg(mode_cfg), .invert_cfg(invert_cfg),
        .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
        .post_frame_de(post_frame_de), .monoc(monoc), .monoc_rise(monoc_rise),
        .monoc_fall(monoc_fall), .auto_thresh(auto_thresh), .white_cnt(white_cnt),
        .white_cnt_valid(white_cnt_valid)
    );

    binarization_adaptive #(.DW(8), .THRESH_INIT(64), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst),
        .pre_frame_vsync(vs_in), .pre_frame_hsync(hs_in), .pre_frame_de(de_in),
        .color(color), .thresh_cfg(thresh_cfg), .hyst_cfg(hyst_cfg),
        .mode_cfg(mode_cfg), .invert_cfg(invert_cfg),
        .post_frame_vsync(pvs3), .post_frame_hsync(phs3), .post_frame_de(pde3),
        .monoc(monoc3), .monoc_rise(rise3), .monoc_fall(fall3),
        .auto_thresh(auto3), .white_cnt(wc3), .white_cnt_valid(wcv3)
    );

    logic [54:0] obs, expv;
    assign obs = {monoc, monoc_rise, monoc_fall, post_frame_vsync, post_frame_hsync,
                  post_frame_de, white_cnt_valid, auto_thresh, white_cnt,
                  monoc3, rise3, fall3, pvs3, phs3, pde3, wcv3, auto3, wc3};

    int vectors = 0;
    int fails   = 0;

    // current configuration applied to pushed samples
    int c_thr = 64, c_hy = 0, c_md = 0;
    bit c_inv = 0;
    smp_t q[$];
    int   lq[$];

    // observation logs
    int got_bits, got_n, rise_n, val_n;

    // reference model state
    smp_t p;
    bit   m_vs_prev, m_de_prev, m_w;
    int   a_thr, a_hy, a_md, a_auto, mn, mx;
    bit   a_inv, seen;
    bit   e_monoc, e_monoc_d, e_pvs, e_phs, e_pde, e_pvs_dly, e_wcv;
    int   cnt, cnt3, e_wc, e_wc3;

    task automatic m_reset();
        p = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        m_vs_prev = 0; m_de_prev = 0; m_w = 0;
        a_thr = 64; a_hy = 0; a_md = 0; a_inv = 0; a_auto = 64;
        mn = PMAX; mx = 0; seen = 0;
        e_monoc = 0; e_monoc_d = 0; e_pvs = 0; e_phs = 0; e_pde = 0;
        e_pvs_dly = 0; e_wcv = 0; cnt = 0; cnt3 = 0; e_wc = 0; e_wc3 = 0;
    endtask

    // apply one sample, advance one clock and update the model's expectations
    task automatic step(input smp_t s);
        int t, hi, lo, inc;
        bit w, rise, fall;
        rst = s.rst; vs_in = s.vs; hs_in = s.hs; de_in = s.de;
        color = 8'(s.col); thresh_cfg = 8'(s.thr); hyst_cfg = 8'(s.hy);
        mode_cfg = 2'(s.md); invert_cfg = s.inv;
        @(posedge clk);
        #1;
        if (s.rst) begin
            m_reset();
        end else begin
            inc = e_monoc ? 1 : 0;
            if (e_pvs && !e_pvs_dly) begin
                e_wc  = (cnt + inc > CMAX) ? CMAX : cnt + inc;
                e_wc3 = (cnt3 + inc > CMAX3) ? CMAX3 : cnt3 + inc;
                e_wcv = 1; cnt = 0; cnt3 = 0;
            end else begin
                e_wcv = 0;
                cnt  = (cnt + inc > CMAX) ? CMAX : cnt + inc;
                cnt3 = (cnt3 + inc > CMAX3) ? CMAX3 : cnt3 + inc;
            end
            e_pvs_dly = e_pvs;
            e_monoc_d = e_monoc;
            if (p.vs && !m_vs_prev) begin
                a_thr = s.thr; a_hy = s.hy; a_md = s.md; a_inv = s.inv;
                if (seen) a_auto = (mn + mx) / 2;
                mn = PMAX; mx = 0; seen = 0;
            end
            m_vs_prev = p.vs;
            if (p.de) begin
                if (p.col < mn) mn = p.col;
                if (p.col > mx) mx = p.col;
                seen = 1;
                t = (a_md % 2 == 1) ? a_auto : a_thr;
                if (a_md >= 2) begin
                    hi = (t + a_hy > PMAX) ? PMAX : t + a_hy;
                    lo = (t - a_hy < 0) ? 0 : t - a_hy;
                    if (!m_de_prev) m_w = 0;
                    if (p.col > hi) w = 1;
                    else if (p.col < lo) w = 0;
                    else w = m_w;
                end else begin
                    w = (p.col > t);
                end
                m_w = w;
                e_monoc = w ^ a_inv;
            end else begin
                e_monoc = 0;
            end
            m_de_prev = p.de;
            e_pvs = p.vs; e_phs = p.hs; e_pde = p.de;
            p = s;
        end
        rise = e_pde && !e_monoc_d && e_monoc;
        fall = e_pde && e_monoc_d && !e_monoc;
        expv = {e_monoc, rise, fall, e_pvs, e_phs, e_pde, e_wcv, 8'(a_auto), 22'(e_wc),
                e_monoc, rise, fall, e_pvs, e_phs, e_pde, e_wcv, 8'(a_auto), 3'(e_wc3)};
        if (e_pde) begin
            got_bits = (got_bits << 1) | (monoc ? 1 : 0);
            got_n++;
        end
        if (monoc_rise) rise_n++;
        if (white_cnt_valid) val_n++;
    endtask

    task automatic clear_logs();
        got_bits = 0; got_n = 0; rise_n = 0; val_n = 0;
    endtask

    task automatic push(input bit r, input bit v, input bit h, input bit d, input int c);
        q.push_back('{r, v, h, d, c, c_thr, c_hy, c_md, c_inv});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(0, 0, 0, 0, 0);
    endtask

    task automatic push_vsync(input int n);
        for (int i = 0; i < n; i++) push(0, 1, 0, 0, 0);
        push_idle(2);
    endtask

    task automatic push_line(input int px[$]);
        push(0, 0, 1, 0, 0);
        foreach (px[i]) push(0, 0, 0, 1, px[i]);
        push_idle(2);
    endtask

    task automatic push_rand_line(input int n, input int lo, input int hi);
        push(0, 0, 1, 0, 0);
        for (int i = 0; i < n; i++) push(0, 0, 0, 1, int'($urandom_range(hi, lo)));
    endtask

    task automatic test_reset();
        push(1, 0, 0, 0, 0); push(1, 0, 0, 0, 0); push_idle(3);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL reset v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if (auto_thresh !== 8'd64 || white_cnt !== 22'd0 || monoc !== 1'b0) begin
            fails++; $display("FAIL reset_values: auto %0d cnt %0d monoc %b, need 64 0 0",
                              auto_thresh, white_cnt, monoc);
        end
    endtask

    task automatic test_fixed();
        clear_logs();
        c_thr = 64; c_md = 0; c_hy = 0; c_inv = 0;
        push_vsync(1);
        lq = '{63, 64, 65, 200}; push_line(lq);
        push_idle(2);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL fixed v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if (got_n !== 4 || got_bits !== 32'b0011 || rise_n !== 1) begin
            fails++; $display("FAIL fixed_seq: bits %b n %0d rises %0d, need 0011 4 1",
                              got_bits, got_n, rise_n);
        end
    endtask

    task automatic test_auto();
        c_md = 1;
        push_vsync(1);
        for (int l = 0; l < 3; l++) push_rand_line(8, 20, 180);
        push_idle(1);
        lq = '{20, 180}; push_line(lq);
        push_vsync(1); push_idle(2);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL auto v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if (auto_thresh !== 8'd100) begin
            fails++; $display("FAIL auto_mid: got %0d need 100", auto_thresh);
        end
        clear_logs();
        lq = '{100, 101}; push_line(lq);
        push_vsync(1); push_idle(3); push_vsync(1); push_idle(2);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL auto_b v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if (got_n !== 2 || got_bits !== 32'b01 || auto_thresh !== 8'd100) begin
            fails++; $display("FAIL auto_empty: bits %b n %0d auto %0d, need 01 2 100",
                              got_bits, got_n, auto_thresh);
        end
    endtask

    task automatic test_hyst();
        clear_logs();
        c_md = 2; c_thr = 100; c_hy = 10;
        push_vsync(1);
        lq = '{95, 111, 105, 95, 89, 105}; push_line(lq);
        lq = '{105}; push_line(lq);
        c_thr = 250;
        push_vsync(1);
        lq = '{255}; push_line(lq);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL hyst v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if (got_n !== 8 || got_bits !== 32'b01110000) begin
            fails++; $display("FAIL hyst_seq: bits %b n %0d, need 01110000 8", got_bits, got_n);
        end
    endtask

    task automatic test_cfg_change();
        clear_logs();
        c_md = 0; c_thr = 64; c_hy = 0; c_inv = 0;
        push_vsync(1);
        lq = '{150}; push_line(lq);
        c_thr = 200; push_line(lq);
        push_vsync(1); push_line(lq);
        c_inv = 1; push_line(lq);
        push_vsync(1); push_line(lq);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL cfg v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if (got_n !== 5 || got_bits !== 32'b11001) begin
            fails++; $display("FAIL cfg_seq: bits %b n %0d, need 11001 5", got_bits, got_n);
        end
    endtask

    task automatic test_white_cnt();
        int fl[32];
        int j, tmp;
        clear_logs();
        c_md = 0; c_thr = 64; c_hy = 0; c_inv = 0;
        for (int i = 0; i < 32; i++) fl[i] = (i < 12) ? 1 : 0;
        for (int i = 31; i > 0; i--) begin
            j = int'($urandom_range(i, 0)); tmp = fl[i]; fl[i] = fl[j]; fl[j] = tmp;
        end
        push_vsync(1);
        for (int l = 0; l < 4; l++) begin
            lq.delete();
            for (int k = 0; k < 8; k++)
                lq.push_back(fl[l*8+k] != 0 ? int'($urandom_range(255, 65)) : int'($urandom_range(64, 0)));
            push_line(lq);
        end
        push_vsync(1); push_idle(3);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL white v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if (white_cnt !== 22'd12 || wc3 !== 3'd7 || val_n !== 2) begin
            fails++; $display("FAIL white_cnt: cnt %0d sat %0d strobes %0d, need 12 7 2",
                              white_cnt, wc3, val_n);
        end
    endtask

    task automatic test_random();
        int nv, nl;
        for (int f = 0; f < 40; f++) begin
            c_md = int'($urandom_range(3, 0)); c_thr = int'($urandom_range(255, 0));
            c_hy = int'($urandom_range(40, 0)); c_inv = 1'($urandom_range(1, 0));
            nv = int'($urandom_range(3, 1));
            if ($urandom_range(1, 0) == 1) begin
                push(0, 1, 0, 1, int'($urandom_range(255, 0)));
                nv--;
            end
            for (int i = 0; i < nv; i++) push(0, 1, 0, 0, 0);
            nl = int'($urandom_range(3, 0));
            for (int l = 0; l < nl; l++) begin
                push_rand_line(int'($urandom_range(10, 1)), 0, 255);
                if ($urandom_range(3, 0) == 0) c_thr = int'($urandom_range(255, 0));
                push_idle(int'($urandom_range(2, 0)));
            end
            push_idle(int'($urandom_range(1, 0)));
            push(0, 0, 0, 0, 0);
        end
        push_vsync(1); push_idle(3);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL random v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
    endtask

    task automatic test_mid_reset();
        c_md = 1; c_hy = 0; c_inv = 0;
        push_vsync(1);
        push_rand_line(3, 0, 255);
        push(1, 0, 0, 1, 77);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL rst_a v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if ({monoc, monoc_rise, monoc_fall, post_frame_vsync, post_frame_hsync,
             post_frame_de, white_cnt_valid, white_cnt} !== 29'd0 || auto_thresh !== 8'd64) begin
            fails++; $display("FAIL rst_outputs: got %h auto %0d, need 0 and 64", obs, auto_thresh);
        end
        push_idle(2); push_vsync(1); push_idle(2);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL rst_b v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if (auto_thresh !== 8'd64) begin
            fails++; $display("FAIL rst_empty: auto %0d need 64", auto_thresh);
        end
        for (int l = 0; l < 3; l++) push_rand_line(6, 30, 90);
        lq = '{90, 30}; push_line(lq);
        push_vsync(1); push_idle(2);
        while (q.size() != 0) begin
            step(q.pop_front());
            vectors++;
            if (obs !== expv) begin
                fails++; $display("FAIL rst_c v%0d: got %h exp %h", vectors, obs, expv);
            end
        end
        vectors++;
        if (auto_thresh !== 8'd60) begin
            fails++; $display("FAIL rst_stats: auto %0d need 60", auto_thresh);
        end
    endtask

    initial begin
        rst = 1'b1; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; color = '0;
        thresh_cfg = 8'd64; hyst_cfg = '0; mode_cfg = 2'b00; invert_cfg = 1'b0;
        m_reset();
        clear_logs();
        test_reset();
        test_fixed();
        test_auto();
        test_hyst();
        test_cfg_change();
        test_white_cnt();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
